// File: rtl/reg_file_write_arbiter_if.sv
// Writeback bus between the requesters and the register-file write arbiter.
// Requester-side signals sit on the master modport. The arbiter uses the slave modport.
interface reg_file_write_arbiter_if #(
  parameter int NUM_REQ    = 3,
  parameter int SEL_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
);
  logic                             freeze;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*SEL_WIDTH-1:0]     req_sel;
  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data;
  logic                             wr_en;
  logic [SEL_WIDTH-1:0]             wr_sel;
  logic [DATA_WIDTH-1:0]            wr_data;
  logic [SEL_WIDTH-1:0]             chk_sel;
  logic                             chk_hit;
  logic                             busy;

  modport master (
    output freeze, req_valid, req_sel, req_data, chk_sel,
    input  req_ready, wr_en, wr_sel, wr_data, chk_hit, busy
  );

  modport slave (
    input  freeze, req_valid, req_sel, req_data, chk_sel,
    output req_ready, wr_en, wr_sel, wr_data, chk_hit, busy
  );
endinterface

// File: rtl/reg_file_write_arbiter.sv
// Round-robin arbiter that shares the register file's single write port.
// A granted write is registered and reaches the register file one cycle after the transfer.
// Optional macro FROST32_REG_WRITE_ARB_R0_DISCARD_EN: writes to register 0 handshake
// normally but are dropped, and pending-write checks of register 0 never hit.
module reg_file_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int SEL_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input logic                    clk,
  input logic                    rst,
  reg_file_write_arbiter_if.slave bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      last_grant;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [NUM_REQ-1:0]    ready;
  logic [SEL_WIDTH-1:0]  grant_sel;
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  grant_keep;
  logic                  wr_en_q;
  logic [SEL_WIDTH-1:0]  wr_sel_q;
  logic [DATA_WIDTH-1:0] wr_data_q;
  logic                  hit;

  // Round-robin search starting just after the last granted requester.
  always_comb begin : arb
    int idx;
    idx       = 0;
    ready     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!grant_any && bus.req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = PTR_W'(idx);
      end
    end
    if (rst || bus.freeze) grant_any = 1'b0;
    if (grant_any) ready[grant_idx] = 1'b1;
  end

  // Select the granted requester's payload and decide whether it reaches the write port.
  always_comb begin
    grant_sel  = bus.req_sel[int'(grant_idx)*SEL_WIDTH +: SEL_WIDTH];
    grant_data = bus.req_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
`ifdef FROST32_REG_WRITE_ARB_R0_DISCARD_EN
    grant_keep = (grant_sel != '0);
`else
    grant_keep = 1'b1;
`endif
  end

  // Pointer and output register. They update only on a transfer. A discarded R0 write leaves sel/data held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PTR_W'(NUM_REQ - 1);
      wr_en_q    <= 1'b0;
      wr_sel_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (grant_any) begin
        last_grant <= grant_idx;
        if (grant_keep) begin
          wr_en_q   <= 1'b1;
          wr_sel_q  <= grant_sel;
          wr_data_q <= grant_data;
        end
      end
    end
  end

  // Pending-write lookup for stall logic: queued requests plus the write on the port.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i] && (bus.req_sel[i*SEL_WIDTH +: SEL_WIDTH] == bus.chk_sel)) hit = 1'b1;
    end
    if (wr_en_q && (wr_sel_q == bus.chk_sel)) hit = 1'b1;
`ifdef FROST32_REG_WRITE_ARB_R0_DISCARD_EN
    if (bus.chk_sel == '0) hit = 1'b0;
`endif
  end

  assign bus.req_ready = ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_sel    = wr_sel_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.chk_hit   = hit;
  assign bus.busy      = (|bus.req_valid) | wr_en_q;
endmodule

// File: tb/tb_reg_file_write_arbiter.sv
// Directed bench for reg_file_write_arbiter: reset, single write, round-robin,
// freeze, hazard lookup, async reset mid-stream and the register-0 write.
module tb_reg_file_write_arbiter;
  localparam int NR = 3;
  localparam int SW = 4;
  localparam int DW = 32;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  reg_file_write_arbiter_if #(.NUM_REQ(NR), .SEL_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

  reg_file_write_arbiter #(.NUM_REQ(NR), .SEL_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [SW-1:0] s, input logic [DW-1:0] d);
    bus.req_sel[i*SW +: SW]  = s;
    bus.req_data[i*DW +: DW] = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.freeze    = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    bus.req_valid = 3'b111;
    tick();
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.wr_sel !== 4'd0) begin failures++; $display("FAIL reset_wr_sel got=%h exp=0", bus.wr_sel); end
    checks++; if (bus.wr_data !== 32'd0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", bus.wr_data); end
    checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL reset_ready_forced got=%b exp=000", bus.req_ready); end
    bus.req_valid = '0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    set_req(0, 4'd5, 32'hDEADBEEF);
    bus.chk_sel   = 4'd5;
    bus.req_valid = 3'b001;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL single_ready got=%b exp=001", bus.req_ready); end
    checks++; if (bus.chk_hit !== 1'b1) begin failures++; $display("FAIL single_chk_req got=%b exp=1", bus.chk_hit); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    tick();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL single_wr_en got=%b exp=1", bus.wr_en); end
    checks++; if (bus.wr_sel !== 4'd5) begin failures++; $display("FAIL single_wr_sel got=%h exp=5", bus.wr_sel); end
    checks++; if (bus.wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_wr_data got=%h exp=deadbeef", bus.wr_data); end
    tick();
    checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL single_idle_wr_en got=%b exp=0", bus.wr_en); end
    checks++; if (bus.wr_sel !== 4'd5) begin failures++; $display("FAIL single_hold_sel got=%h exp=5", bus.wr_sel); end
    checks++; if (bus.wr_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold_data got=%h exp=deadbeef", bus.wr_data); end
  endtask

  task automatic test_round_robin();
    logic [2:0]  exp_ready;
    logic [3:0]  exp_sel;
    logic [31:0] exp_data;
    do_reset();
    set_req(0, 4'd1, 32'hA0A0_0001);
    set_req(1, 4'd2, 32'hB0B0_0002);
    set_req(2, 4'd3, 32'hC0C0_0003);
    bus.req_valid = 3'b111;
    for (int c = 0; c < 6; c++) begin
      exp_ready = 3'b001 << (c % 3);
      exp_sel   = 4'(c % 3 + 1);
      exp_data  = (c % 3 == 0) ? 32'hA0A0_0001 : (c % 3 == 1) ? 32'hB0B0_0002 : 32'hC0C0_0003;
      #1;
      checks++; if (bus.req_ready !== exp_ready) begin failures++; $display("FAIL rr_ready[%0d] got=%b exp=%b", c, bus.req_ready, exp_ready); end
      tick();
      checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL rr_wr_en[%0d] got=%b exp=1", c, bus.wr_en); end
      checks++; if (bus.wr_sel !== exp_sel) begin failures++; $display("FAIL rr_wr_sel[%0d] got=%h exp=%h", c, bus.wr_sel, exp_sel); end
      checks++; if (bus.wr_data !== exp_data) begin failures++; $display("FAIL rr_wr_data[%0d] got=%h exp=%h", c, bus.wr_data, exp_data); end
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_freeze();
    do_reset();
    set_req(0, 4'd1, 32'h11);
    set_req(1, 4'd2, 32'h22);
    set_req(2, 4'd3, 32'h33);
    bus.req_valid = 3'b111;
    tick();
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin failures++; $display("FAIL frz_pre_ready got=%b exp=010", bus.req_ready); end
    tick();
    bus.freeze = 1'b1;
    #1;
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_sel !== 4'd2) begin failures++; $display("FAIL frz_inflight got=%b/%h exp=1/2", bus.wr_en, bus.wr_sel); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL frz_ready[%0d] got=%b exp=000", c, bus.req_ready); end
      tick();
      checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL frz_wr_en[%0d] got=%b exp=0", c, bus.wr_en); end
      checks++; if (bus.wr_sel !== 4'd2) begin failures++; $display("FAIL frz_hold_sel[%0d] got=%h exp=2", c, bus.wr_sel); end
    end
    bus.freeze = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b100) begin failures++; $display("FAIL frz_release_ready got=%b exp=100", bus.req_ready); end
    tick();
    checks++; if (bus.wr_sel !== 4'd3 || bus.wr_data !== 32'h33) begin failures++; $display("FAIL frz_release_wr got=%h/%h exp=3/33", bus.wr_sel, bus.wr_data); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_hazard();
    do_reset();
    set_req(2, 4'd7, 32'h7777);
    bus.freeze    = 1'b1;
    bus.req_valid = 3'b100;
    bus.chk_sel   = 4'd7;
    tick();
    checks++; if (bus.chk_hit !== 1'b1) begin failures++; $display("FAIL haz_pending_hit got=%b exp=1", bus.chk_hit); end
    checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL haz_frozen_ready got=%b exp=000", bus.req_ready); end
    bus.chk_sel = 4'd6;
    #1;
    checks++; if (bus.chk_hit !== 1'b0) begin failures++; $display("FAIL haz_other_miss got=%b exp=0", bus.chk_hit); end
    bus.chk_sel = 4'd7;
    bus.freeze  = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b100) begin failures++; $display("FAIL haz_ready got=%b exp=100", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.chk_hit !== 1'b1) begin failures++; $display("FAIL haz_inflight_hit got=%b exp=1", bus.chk_hit); end
    tick();
    checks++; if (bus.chk_hit !== 1'b0) begin failures++; $display("FAIL haz_done_miss got=%b exp=0", bus.chk_hit); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL haz_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_req(0, 4'd9, 32'h5555);
    set_req(1, 4'd10, 32'h6666);
    set_req(2, 4'd11, 32'h7777);
    bus.req_valid = 3'b001;
    tick();
    bus.req_valid = 3'b111;
    #1;
    checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL arst_pre_wr_en got=%b exp=1", bus.wr_en); end
    rst = 1'b1;
    #1;
    checks++; if (bus.wr_en !== 1'b0 || bus.wr_sel !== 4'd0 || bus.wr_data !== 32'd0) begin
      failures++; $display("FAIL arst_clear got=%b/%h/%h exp=0/0/0", bus.wr_en, bus.wr_sel, bus.wr_data); end
    checks++; if (bus.req_ready !== 3'b000) begin failures++; $display("FAIL arst_ready got=%b exp=000", bus.req_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL arst_first_grant got=%b exp=001", bus.req_ready); end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_r0_write();
    do_reset();
    set_req(1, 4'd3, 32'hAA);
    bus.req_valid = 3'b010;
    tick();
    set_req(0, 4'd0, 32'h1);
    bus.req_valid = 3'b001;
    bus.chk_sel   = 4'd0;
    #1;
    checks++; if (bus.req_ready !== 3'b001) begin failures++; $display("FAIL r0_ready got=%b exp=001", bus.req_ready); end
`ifdef FROST32_REG_WRITE_ARB_R0_DISCARD_EN
    checks++; if (bus.chk_hit !== 1'b0) begin failures++; $display("FAIL r0_chk got=%b exp=0", bus.chk_hit); end
    tick();
    checks++; if (bus.wr_en !== 1'b0 || bus.wr_sel !== 4'd3 || bus.wr_data !== 32'hAA) begin
      failures++; $display("FAIL r0_discard got=%b/%h/%h exp=0/3/aa", bus.wr_en, bus.wr_sel, bus.wr_data); end
`else
    checks++; if (bus.chk_hit !== 1'b1) begin failures++; $display("FAIL r0_chk got=%b exp=1", bus.chk_hit); end
    tick();
    checks++; if (bus.wr_en !== 1'b1 || bus.wr_sel !== 4'd0 || bus.wr_data !== 32'h1) begin
      failures++; $display("FAIL r0_write got=%b/%h/%h exp=1/0/1", bus.wr_en, bus.wr_sel, bus.wr_data); end
`endif
    set_req(0, 4'd4, 32'h44);
    set_req(1, 4'd5, 32'h55);
    bus.req_valid = 3'b011;
    #1;
    checks++; if (bus.req_ready !== 3'b010) begin failures++; $display("FAIL r0_ptr_advanced got=%b exp=010", bus.req_ready); end
    bus.req_valid = '0;
    tick();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst           = 1'b1;
    bus.freeze    = 1'b0;
    bus.req_valid = '0;
    bus.req_sel   = '0;
    bus.req_data  = '0;
    bus.chk_sel   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_freeze();
    test_hazard();
    test_async_reset();
    test_r0_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_file_write_arbiter.md
Name: reg_file_write_arbiter

Overview:
Shares the register file's single write port (write_sel / write_data / write_en) between several writeback requesters, such as the ALU, the multiply/divide unit and the load unit. Each requester uses a valid/ready handshake, and the block grants them round-robin. The granted write is registered and presented to the register file one cycle later. The block also provides a combinational pending-write check that stall logic uses to detect in-flight writes to a source register.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
SEL_WIDTH, 4, register select width (MSB_POS__REG_FILE_SEL + 1)
DATA_WIDTH, 32, register data width (MSB_POS__REG_FILE_DATA + 1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
freeze  in  1  when 1: no grants this cycle, round-robin pointer held
req_valid  in  NUM_REQ  per-requester write request
req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
req_sel  in  NUM_REQ*SEL_WIDTH  destination register; requester i at bits [i*SEL_WIDTH +: SEL_WIDTH]
req_data  in  NUM_REQ*DATA_WIDTH  write data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH]
wr_en  out  1  to register file write_en
wr_sel  out  SEL_WIDTH  to register file write_sel
wr_data  out  DATA_WIDTH  to register file write_data
chk_sel  in  SEL_WIDTH  register being queried by stall logic
chk_hit  out  1  1 if a write to chk_sel is pending or in flight
busy  out  1  1 if any req_valid or wr_en

Behaviour:
- Reset (async, rst=1):
  - wr_en=0, wr_sel=0, wr_data=0
  - pointer last_grant=NUM_REQ-1, so requester 0 has first priority
  - req_ready is combinational and reads 0 while every req_valid=0
- Arbitration (combinational, every cycle):
  - Search order starts at (last_grant+1) mod NUM_REQ and wraps to last_grant.
  - The first requester with req_valid=1 gets req_ready=1; all others get 0.
  - freeze=1 or rst=1 forces req_ready=0.
- Transfer: occurs when req_valid[i] & req_ready[i].
- Requester rules: once asserted, req_valid, req_sel and req_data are held stable until transfer. Dropping req_valid before transfer is illegal.
- Pointer: last_grant<=i on transfer only. Unchanged on idle or freeze cycles.
- Output register (latency 1 cycle from transfer):
  - Cycle after a transfer: wr_en=1, wr_sel=req_sel[i], wr_data=req_data[i].
  - Cycle with no transfer: wr_en=0; wr_sel and wr_data hold their previous values.
- Throughput: one write per cycle. Back-to-back transfers produce consecutive wr_en=1 cycles.
- Several requesters with the same req_sel are serialized in round-robin order; there is no merging.
  - The later-granted write lands one or more cycles after the earlier one.
  - Ordering between requesters is not guaranteed beyond round-robin.
- Fairness: a requester held valid is granted within NUM_REQ non-frozen cycles.
- chk_hit (combinational) = OR of:
  - any i with req_valid[i] and req_sel[i]==chk_sel
  - wr_en and wr_sel==chk_sel
- busy = |req_valid | wr_en.
- Reset mid-operation: the output register and pointer clear immediately. Un-transferred requests are not remembered; requesters re-present them after reset. An in-flight wr_en is lost.
- freeze asserted while the output register is valid: that write still completes (wr_en=1 for its cycle). freeze only blocks new grants.

Optional Feature:
Macro FROST32_REG_WRITE_ARB_R0_DISCARD_EN.
- Defined:
  - A transfer with req_sel==0 handshakes normally and advances the pointer.
  - The next cycle has wr_en=0, and wr_sel/wr_data hold.
  - chk_hit is forced to 0 when chk_sel==0.
- Not defined: register 0 is treated like any other register.

Test Plan:
- Reset then single request: rst released; req_valid=3'b001, sel=5, data=32'hDEADBEEF -> req_ready=3'b001 same cycle; next cycle wr_en=1, wr_sel=5, wr_data=32'hDEADBEEF; following cycle wr_en=0, sel/data held.
- Round-robin: all three valid continuously from reset, sels 1/2/3 -> grants in order 0,1,2,0,1,2; wr_sel sequence 1,2,3,1,2,3 with wr_en=1 every cycle.
- Freeze: all valid, freeze=1 for 3 cycles after req1 granted -> req_ready=0 and pointer held; next output after the in-flight write is wr_en=0 for 3 cycles; first grant after release goes to req2.
- Hazard check: req2 valid sel=7 stalled by freeze; chk_sel=7 -> chk_hit=1; chk_sel=6 -> 0. After grant, chk_hit=1 for the wr_en cycle, then 0.
- Async reset mid-stream: rst pulsed between clock edges while wr_en=1 -> wr_en, wr_sel, wr_data go to 0 immediately; first post-reset grant goes to req0.
- R0 discard (macro defined): req0 sel=0 data=32'h1 -> ready=1, next cycle wr_en=0, pointer advanced; chk_sel=0 -> chk_hit=0. Without the macro: wr_en=1, wr_sel=0.
